// File: rtl/combo_lock_ctrl.sv
// Combination lock controller: collects button symbols, compares the full entry
// against CODE, opens for a tick-timed window and locks out after repeated failures.
module combo_lock_ctrl #(
  parameter int unsigned CODE_LEN    = 4,
  parameter logic [13:0] CODE        = 14'b00_0000_0110_0001,
  parameter int unsigned ENTRY_TICKS = 8,
  parameter int unsigned OPEN_TICKS  = 16,
  parameter int unsigned MAX_FAILS   = 3,
  parameter int unsigned LOCK_TICKS  = 32
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       btn0,
  input  logic       btn1,
  input  logic       btn2,
  input  logic       tick,
  output logic       unlock,
  output logic       alarm,
  output logic       busy,
  output logic       fail_pulse,
  output logic [2:0] digits
);

  localparam int unsigned TICK_AB  = (ENTRY_TICKS > OPEN_TICKS) ? ENTRY_TICKS : OPEN_TICKS;
  localparam int unsigned TICK_MAX = (TICK_AB > LOCK_TICKS) ? TICK_AB : LOCK_TICKS;
  localparam int unsigned TICK_W   = $clog2(TICK_MAX + 1);
  localparam int unsigned FAIL_W   = $clog2(MAX_FAILS + 1);

  localparam logic [TICK_W-1:0] ENTRY_LAST = TICK_W'(ENTRY_TICKS - 1);
  localparam logic [TICK_W-1:0] OPEN_LAST  = TICK_W'(OPEN_TICKS - 1);
  localparam logic [TICK_W-1:0] LOCK_LAST  = TICK_W'(LOCK_TICKS - 1);
  localparam logic [FAIL_W-1:0] FAIL_LIMIT = FAIL_W'(MAX_FAILS);
  localparam logic [2:0]        FULL_LEN   = 3'(CODE_LEN);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ENTRY   = 2'd1;
  localparam logic [1:0] ST_OPEN    = 2'd2;
  localparam logic [1:0] ST_LOCKOUT = 2'd3;

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [2:0]        digits_r;
  logic [2:0]        digits_nxt_s;
  logic [TICK_W-1:0] tick_cnt_r;
  logic [TICK_W-1:0] tick_cnt_nxt_s;
  logic [FAIL_W-1:0] fail_cnt_r;
  logic [FAIL_W-1:0] fail_cnt_nxt_s;
  logic [FAIL_W-1:0] fail_inc_s;
  logic [13:0]       entry_r;
  logic [13:0]       entry_nxt_s;
  logic              fail_pulse_nxt_s;
  logic [2:0]        btns_s;
  logic              press_s;
  logic [1:0]        sym_s;
  logic              match_s;

  function automatic logic one_press(input logic [2:0] btns);
    logic res;
    case (btns)
      3'b001, 3'b010, 3'b100: res = 1'b1;
      default:                res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic [1:0] press_sym(input logic [2:0] btns);
    logic [1:0] res;
    case (btns)
      3'b010:  res = 2'd1;
      3'b100:  res = 2'd2;
      default: res = 2'd0;
    endcase
    return res;
  endfunction

  function automatic logic code_match(input logic [13:0] entry);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if ((i < int'(CODE_LEN)) && (entry[2*i +: 2] != CODE[2*i +: 2])) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  assign btns_s     = {btn2, btn1, btn0};
  assign press_s    = one_press(btns_s);
  assign sym_s      = press_sym(btns_s);
  assign match_s    = code_match(entry_r);
  assign fail_inc_s = (fail_cnt_r < FAIL_LIMIT) ? (fail_cnt_r + FAIL_W'(1)) : fail_cnt_r;
  assign digits     = digits_r;

  // Next-state logic; a full entry is judged on the cycle after its last press.
  always_comb begin
    state_nxt_s      = state_r;
    digits_nxt_s     = digits_r;
    tick_cnt_nxt_s   = tick_cnt_r;
    fail_cnt_nxt_s   = fail_cnt_r;
    entry_nxt_s      = entry_r;
    fail_pulse_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (press_s) begin
          state_nxt_s    = ST_ENTRY;
          digits_nxt_s   = 3'd1;
          tick_cnt_nxt_s = '0;
          entry_nxt_s    = {12'd0, sym_s};
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ENTRY: begin
        if (digits_r == FULL_LEN) begin
          digits_nxt_s   = 3'd0;
          tick_cnt_nxt_s = '0;
          entry_nxt_s    = 14'd0;
          if (match_s) begin
            state_nxt_s    = ST_OPEN;
            fail_cnt_nxt_s = '0;
          end else begin
            fail_pulse_nxt_s = 1'b1;
            fail_cnt_nxt_s   = fail_inc_s;
            state_nxt_s      = (fail_inc_s == FAIL_LIMIT) ? ST_LOCKOUT : ST_IDLE;
          end
        end else if (press_s) begin
          entry_nxt_s[{digits_r, 1'b0} +: 2] = sym_s;
          digits_nxt_s   = digits_r + 3'd1;
          tick_cnt_nxt_s = '0;
        end else if (tick) begin
          if (tick_cnt_r == ENTRY_LAST) begin
            state_nxt_s    = ST_IDLE;
            digits_nxt_s   = 3'd0;
            tick_cnt_nxt_s = '0;
            entry_nxt_s    = 14'd0;
          end else begin
            tick_cnt_nxt_s = tick_cnt_r + TICK_W'(1);
          end
        end else begin
          tick_cnt_nxt_s = tick_cnt_r;
        end
      end
      ST_OPEN: begin
        if (tick) begin
          if (tick_cnt_r == OPEN_LAST) begin
            state_nxt_s    = ST_IDLE;
            tick_cnt_nxt_s = '0;
          end else begin
            tick_cnt_nxt_s = tick_cnt_r + TICK_W'(1);
          end
        end else begin
          tick_cnt_nxt_s = tick_cnt_r;
        end
      end
      ST_LOCKOUT: begin
        if (tick) begin
          if (tick_cnt_r == LOCK_LAST) begin
            state_nxt_s    = ST_IDLE;
            tick_cnt_nxt_s = '0;
            fail_cnt_nxt_s = '0;
          end else begin
            tick_cnt_nxt_s = tick_cnt_r + TICK_W'(1);
          end
        end else begin
          tick_cnt_nxt_s = tick_cnt_r;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        digits_nxt_s   = 3'd0;
        tick_cnt_nxt_s = '0;
        fail_cnt_nxt_s = '0;
        entry_nxt_s    = 14'd0;
      end
    endcase
  end

  // Core state registers.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      digits_r   <= 3'd0;
      tick_cnt_r <= '0;
      fail_cnt_r <= '0;
      entry_r    <= 14'd0;
    end else begin
      state_r    <= state_nxt_s;
      digits_r   <= digits_nxt_s;
      tick_cnt_r <= tick_cnt_nxt_s;
      fail_cnt_r <= fail_cnt_nxt_s;
      entry_r    <= entry_nxt_s;
    end
  end

  // Status outputs are registered from the next state so they track state_r exactly.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      unlock     <= 1'b0;
      alarm      <= 1'b0;
      busy       <= 1'b0;
      fail_pulse <= 1'b0;
    end else begin
      unlock     <= (state_nxt_s == ST_OPEN);
      alarm      <= (state_nxt_s == ST_LOCKOUT);
      busy       <= (state_nxt_s != ST_IDLE);
      fail_pulse <= fail_pulse_nxt_s;
    end
  end

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Scoreboard bench for combo_lock_ctrl: directed scenarios plus random stimulus
// checked cycle by cycle against a queue-based behavioural model.
module tb_combo_lock_ctrl;

  localparam int CODE_LEN    = 4;
  localparam int ENTRY_TICKS = 8;
  localparam int OPEN_TICKS  = 16;
  localparam int MAX_FAILS   = 3;
  localparam int LOCK_TICKS  = 32;

  logic       sysclk;
  logic       reset;
  logic       btn0, btn1, btn2, tick;
  logic       unlock, alarm, busy, fail_pulse;
  logic [2:0] digits;

  int checks   = 0;
  int failures = 0;

  logic [6:0] exp_q[$];
  string      tag_q[$];

  // Behavioural model: entered symbols kept as a queue, timers count down.
  int code_syms[4] = '{1, 0, 2, 1};
  int m_syms[$];
  bit m_open, m_lock;
  int m_remain, m_idle, m_fails;

  combo_lock_ctrl dut (
    .sysclk(sysclk), .reset(reset),
    .btn0(btn0), .btn1(btn1), .btn2(btn2), .tick(tick),
    .unlock(unlock), .alarm(alarm), .busy(busy),
    .fail_pulse(fail_pulse), .digits(digits)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic model_clear();
    m_syms.delete();
    m_open = 1'b0; m_lock = 1'b0;
    m_remain = 0; m_idle = 0; m_fails = 0;
  endtask

  task automatic model_cycle(input logic b0, b1, b2, tk, output logic [6:0] e);
    int n, sym;
    bit press, fp, match;
    n     = int'(b0) + int'(b1) + int'(b2);
    press = (n == 1);
    sym   = b0 ? 0 : (b1 ? 1 : 2);
    fp    = 1'b0;
    if (m_open) begin
      if (tk) begin
        m_remain--;
        if (m_remain == 0) m_open = 1'b0;
      end
    end else if (m_lock) begin
      if (tk) begin
        m_remain--;
        if (m_remain == 0) begin
          m_lock  = 1'b0;
          m_fails = 0;
        end
      end
    end else if (m_syms.size() == CODE_LEN) begin
      match = 1'b1;
      foreach (m_syms[i]) if (m_syms[i] != code_syms[i]) match = 1'b0;
      m_syms.delete();
      m_idle = 0;
      if (match) begin
        m_open = 1'b1; m_remain = OPEN_TICKS; m_fails = 0;
      end else begin
        fp = 1'b1;
        m_fails = (m_fails + 1 > MAX_FAILS) ? MAX_FAILS : m_fails + 1;
        if (m_fails == MAX_FAILS) begin
          m_lock = 1'b1; m_remain = LOCK_TICKS;
        end
      end
    end else if (m_syms.size() > 0) begin
      if (press) begin
        m_syms.push_back(sym); m_idle = 0;
      end else if (tk) begin
        m_idle++;
        if (m_idle == ENTRY_TICKS) begin
          m_syms.delete(); m_idle = 0;
        end
      end
    end else if (press) begin
      m_syms.push_back(sym); m_idle = 0;
    end
    e = {m_open, m_lock, (m_open || m_lock || (m_syms.size() > 0)), fp, 3'(m_syms.size())};
  endtask

  task automatic step(input logic b0, b1, b2, tk, input string tag);
    logic [6:0] e;
    btn0 = b0; btn1 = b1; btn2 = b2; tick = tk;
    model_cycle(b0, b1, b2, tk, e);
    @(posedge sysclk);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    btn0 = 1'b0; btn1 = 1'b0; btn2 = 1'b0; tick = 1'b0;
  endtask

  task automatic press(input int k, input string tag);
    step(k == 0, k == 1, k == 2, 1'b0, tag);
  endtask

  task automatic ticks(input int n, input string tag);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b1, tag);
  endtask

  task automatic idle(input int n, input string tag);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic enter_code(input int a, b, c, d, input string tag);
    press(a, tag); press(b, tag); press(c, tag); press(d, tag);
  endtask

  task automatic check_quiet(input string tag);
    logic [6:0] act;
    act = {unlock, alarm, busy, fail_pulse, digits};
    checks++;
    if (act !== 7'd0) begin
      failures++;
      $display("FAIL %s: got u/a/b/f/d=%b required=%b", tag, act, 7'd0);
    end
  endtask

  task automatic async_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    check_quiet({tag, "_async"});
    exp_q.delete();
    tag_q.delete();
    model_clear();
    repeat (2) @(posedge sysclk);
    #1;
    check_quiet({tag, "_held"});
    reset = 1'b1;
  endtask

  // Monitor: one expected output vector per clocked cycle, sampled mid-period.
  initial begin
    logic [6:0] e, act;
    string t;
    forever begin
      @(negedge sysclk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        act = {unlock, alarm, busy, fail_pulse, digits};
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL %s: got u/a/b/f/d=%b required=%b", t, act, e);
        end
      end
    end
  end

  initial begin
    int r, k;
    reset = 1'b0;
    btn0 = 1'b0; btn1 = 1'b0; btn2 = 1'b0; tick = 1'b0;
    model_clear();
    repeat (3) @(posedge sysclk);
    #1;
    check_quiet("reset_state");
    reset = 1'b1;

    enter_code(1, 0, 2, 1, "open_seq");
    idle(1, "open_eval");
    ticks(16, "open_window");
    idle(2, "open_done");

    repeat (3) begin
      enter_code(0, 0, 0, 0, "wrong_attempt");
      idle(1, "wrong_eval");
    end
    press(1, "lockout_press"); press(2, "lockout_press"); press(0, "lockout_press");
    ticks(32, "lockout_window");
    idle(2, "lockout_done");

    press(1, "abandon_p"); press(0, "abandon_p");
    ticks(8, "abandon_ticks");
    idle(1, "abandon_idle");
    enter_code(1, 0, 2, 1, "after_abandon");
    idle(1, "after_abandon_eval");
    ticks(16, "after_abandon_open");

    step(1'b1, 1'b0, 1'b1, 1'b0, "double_press");
    idle(1, "double_idle");
    press(1, "coincide_p");
    ticks(7, "coincide_ticks");
    step(1'b1, 1'b0, 1'b0, 1'b1, "press_with_tick");
    ticks(7, "no_timeout");
    ticks(1, "late_timeout");
    idle(1, "coincide_done");

    repeat (3) begin
      enter_code(0, 0, 0, 0, "pre_reset_wrong");
      idle(1, "pre_reset_eval");
    end
    ticks(3, "lockout_partial");
    async_reset("lockout_reset");
    enter_code(0, 0, 0, 0, "post_reset_wrong");
    idle(2, "post_reset_eval");

    repeat (2) begin
      enter_code(2, 2, 1, 0, "two_wrong");
      idle(1, "two_wrong_eval");
    end
    enter_code(1, 0, 2, 1, "correct_clears");
    idle(1, "correct_eval");
    ticks(16, "correct_open");
    enter_code(0, 1, 2, 0, "one_more_wrong");
    idle(2, "one_more_eval");

    for (int i = 0; i < 1500; i++) begin
      if (i % 250 == 100) enter_code(1, 0, 2, 1, "rand_code");
      if (i == 777) async_reset("rand_reset");
      r = $urandom_range(0, 99);
      k = $urandom_range(0, 2);
      if (r < 22)      step(k == 0, k == 1, k == 2, $urandom_range(0, 3) == 0, "rand");
      else if (r < 27) step(k != 0, k != 1, k != 2, $urandom_range(0, 3) == 0, "rand_multi");
      else             step(1'b0, 1'b0, 1'b0, $urandom_range(0, 2) == 0, "rand");
    end

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge sysclk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
